// File: rtl/uart_rx_frame.sv
//------------------------------------------------------------------------------
// uart_rx_frame
//
// Oversampling UART frame receiver: start bit, Width data bits (LSB first),
// optional parity bit, one stop bit. The line is oversampled PRESCALE times
// per bit. Each completed frame produces a one-cycle result pulse and updates
// the parallel data word.
//
// Build option:
//   UART_RX_MAJ_VOTE_EN  - when defined, each bit is decided by a 2-of-3
//                          majority over the three samples around the bit
//                          centre. When undefined, a single centre sample is
//                          used.
//
// Ports:
//   CLK        in   1      clock, all registers update on the rising edge
//   RST        in   1      synchronous active-high reset
//   RX_IN      in   1      serial line, idle high, synchronous to CLK
//   PRESCALE   in   6      CLK cycles per bit (8, 16 or 32)
//   PAR_EN     in   1      1 = frame carries a parity bit
//   PAR_TYP    in   1      1 = even parity, 0 = odd parity
//   P_DATA     out  Width  last received data word
//   Data_valid out  1      one-cycle pulse, frame received without error
//   par_err    out  1      one-cycle pulse, parity mismatch
//   stp_err    out  1      one-cycle pulse, stop bit sampled low
//   busy       out  1      high whenever the receiver is not idle
//------------------------------------------------------------------------------
module uart_rx_frame #(
   parameter int Width = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RX_IN,
   input  logic [5:0]       PRESCALE,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic [Width-1:0] P_DATA,
   output logic             Data_valid,
   output logic             par_err,
   output logic             stp_err,
   output logic             busy
);

   // FSM state encodings
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam int BW = (Width > 1) ? $clog2(Width) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(Width - 1);

   // State and counters
   logic [2:0]       r_state;
   logic [2:0]       w_next_state;
   logic [5:0]       r_edge_cnt;
   logic [BW-1:0]    r_bit_cnt;

   // Frame configuration captured at the start edge
   logic [5:0]       r_prescale;
   logic             r_par_en;
   logic             r_par_typ;

   // Datapath
   logic             r_armed;
   logic [Width-1:0] r_shift;
   logic             r_start_bit;
   logic             r_par_bad;

   // Registered results
   logic [Width-1:0] r_p_data;
   logic             r_data_valid;
   logic             r_par_err;
   logic             r_stp_err;

   // Sampling control
   logic [5:0]       w_half;
   logic [5:0]       w_dec_idx;
   logic             w_dec_bit;
   logic             w_dec_pt;
   logic             w_edge_last;
   logic             w_start;
   logic             w_par_exp;

   assign w_half      = {1'b0, r_prescale[5:1]};
   assign w_edge_last = (r_edge_cnt == r_prescale - 6'd1);
   assign w_dec_pt    = (r_state != IDLE) && (r_edge_cnt == w_dec_idx);

   // r_armed keeps a line that is already low when reset is released from
   // being taken as a start bit; reception begins at the first high-to-low
   // transition seen after reset.
   assign w_start     = (r_state == IDLE) && r_armed && !RX_IN;

   // Even parity: parity bit equals XOR of the data; odd parity: XNOR.
   assign w_par_exp   = r_par_typ ? (^r_shift) : ~(^r_shift);

   //---------------------------------------------------------------------------
   // Bit decision
   //---------------------------------------------------------------------------
`ifdef UART_RX_MAJ_VOTE_EN
   logic [1:0] r_smp;

   // The first two samples are held; the third is the live line at the
   // decision point, so the vote completes one cycle after the centre.
   assign w_dec_idx = w_half + 6'd1;
   assign w_dec_bit = (r_smp[0] & r_smp[1]) |
                      (r_smp[0] & RX_IN)    |
                      (r_smp[1] & RX_IN);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_smp <= '0;
      end else if (r_state != IDLE) begin
         if (r_edge_cnt == w_half - 6'd1) begin
            r_smp[0] <= RX_IN;
         end
         if (r_edge_cnt == w_half) begin
            r_smp[1] <= RX_IN;
         end
      end
   end
`else
   assign w_dec_idx = w_half;
   assign w_dec_bit = RX_IN;
`endif

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_next_state = START;
            end
         end
         START: begin
            if (w_edge_last) begin
               w_next_state = r_start_bit ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_edge_last && (r_bit_cnt == LAST_BIT)) begin
               w_next_state = r_par_en ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (w_edge_last) begin
               w_next_state = STOP;
            end
         end
         STOP: begin
            // Leave at the decision point so the remainder of the stop bit
            // is spent in IDLE, ready for a back-to-back start edge.
            if (w_dec_pt) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Per-bit oversampling counter
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_edge_cnt <= '0;
      end else if ((r_state == IDLE) || (w_next_state == IDLE) || w_edge_last) begin
         r_edge_cnt <= '0;
      end else begin
         r_edge_cnt <= r_edge_cnt + 6'd1;
      end
   end

   //---------------------------------------------------------------------------
   // Data bit counter
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST || (r_state != DATA)) begin
         r_bit_cnt <= '0;
      end else if (w_edge_last) begin
         if (r_bit_cnt == LAST_BIT) begin
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Frame configuration, frozen for the duration of a frame
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_prescale <= 6'd8;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
      end else if (w_start) begin
         r_prescale <= PRESCALE;
         r_par_en   <= PAR_EN;
         r_par_typ  <= PAR_TYP;
      end
   end

   //---------------------------------------------------------------------------
   // Start-edge qualifier
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_armed <= 1'b0;
      end else if (RX_IN) begin
         r_armed <= 1'b1;
      end
   end

   //---------------------------------------------------------------------------
   // Start bit, data shift register and parity check
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_start_bit <= 1'b0;
      end else if ((r_state == START) && w_dec_pt) begin
         r_start_bit <= w_dec_bit;
      end
   end

   // Shift right so the first received bit ends up in bit 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_shift <= '0;
      end else if ((r_state == DATA) && w_dec_pt) begin
         r_shift <= (r_shift >> 1) | (Width'(w_dec_bit) << (Width - 1));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || w_start) begin
         r_par_bad <= 1'b0;
      end else if ((r_state == PARITY) && w_dec_pt) begin
         r_par_bad <= w_dec_bit ^ w_par_exp;
      end
   end

   //---------------------------------------------------------------------------
   // Frame result: data word and exactly one status pulse
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
         if ((r_state == STOP) && w_dec_pt) begin
            r_p_data     <= r_shift;
            r_stp_err    <= ~w_dec_bit;
            r_par_err    <= w_dec_bit & r_par_bad;
            r_data_valid <= w_dec_bit & ~r_par_bad;
         end
      end
   end

   assign P_DATA     = r_p_data;
   assign Data_valid = r_data_valid;
   assign par_err    = r_par_err;
   assign stp_err    = r_stp_err;
   assign busy       = (r_state != IDLE);

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter Width, default 8: number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  clock; every register updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port RX_IN  input  1  serial line; idle high; already synchronous to CLK.
REQ-005 SHALL have port PRESCALE  input  6  CLK cycles per bit; legal values 8, 16, 32.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  1 = even parity, 0 = odd parity, matching the transmit-side parity convention.
REQ-008 SHALL have port P_DATA  output  Width  last received data word, LSB received first.
REQ-009 SHALL have port Data_valid  output  1  one-cycle pulse: frame received without error.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse: parity mismatch.
REQ-011 SHALL have port stp_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; per-bit counter edge_cnt runs 0..PRESCALE-1, bit counter bit_cnt runs 0..Width-1.
REQ-014 IDLE: RX_IN sampled 0 SHALL move to START with edge_cnt=0 and latch PRESCALE, PAR_EN and PAR_TYP; changes to these inputs mid-frame SHALL be ignored.
REQ-015 Bit decision SHALL be made at edge_cnt == PRESCALE/2 (or per REQ-028).
REQ-016 START: at edge_cnt == PRESCALE-1, a decided start bit of 1 SHALL return to IDLE (glitch, no outputs); otherwise go to DATA.
REQ-017 DATA: each decided bit SHALL shift in LSB-first; after bit Width-1 completes, go to PARITY if PAR_EN, else STOP.
REQ-018 PARITY: the expected bit SHALL be XOR of data when PAR_TYP=1 and XNOR when PAR_TYP=0; a mismatch is recorded; go to STOP at edge_cnt == PRESCALE-1.
REQ-019 STOP: at the decision point, SHALL go to IDLE immediately without waiting for the end of the bit, so a back-to-back start edge is not missed.
REQ-020 The cycle after the STOP decision SHALL update P_DATA and pulse exactly one of Data_valid, par_err, stp_err; stp_err SHALL take priority over par_err.
REQ-021 P_DATA SHALL update on every completed frame, including errored frames, and SHALL hold between frames.
REQ-022 Next start detection SHALL be possible in the same cycle the result pulse is issued.

Reset
REQ-023 RST high SHALL force IDLE, clear edge_cnt and bit_cnt, set P_DATA=0, Data_valid=0, par_err=0, stp_err=0 and busy=0.
REQ-024 RST asserted mid-frame SHALL abort the frame with no result pulse; reception SHALL restart at the next falling edge after RST deasserts.

Configuration
REQ-025 Macro UART_RX_MAJ_VOTE_EN SHALL select the bit sampling method.
REQ-026 With UART_RX_MAJ_VOTE_EN defined: RX_IN SHALL be sampled at edge_cnt PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1; the bit decision SHALL be the 2-of-3 majority, taken at PRESCALE/2+1.
REQ-027 Without UART_RX_MAJ_VOTE_EN: the bit decision SHALL be a single sample at PRESCALE/2.
REQ-028 The result pulse timing in REQ-020 SHALL follow the decision point of the selected method.

Verification
REQ-029 PRESCALE=8, PAR_EN=1, PAR_TYP=1, frame 0xA5 with parity 0 and stop 1 -> P_DATA=0xA5, one Data_valid pulse, par_err=0, stp_err=0.
REQ-030 Same frame with parity bit 1 -> par_err pulses once, Data_valid stays 0, P_DATA=0xA5.
REQ-031 PRESCALE=16, PAR_EN=0, frame 0x3C with stop bit 0 -> stp_err pulses once, Data_valid=0.
REQ-032 RX_IN low for 3 cycles at PRESCALE=16, then high -> FSM returns to IDLE, no pulses, busy drops after 16 cycles.
REQ-033 Two back-to-back frames 0x01 then 0xFF at PRESCALE=8, no idle gap -> two Data_valid pulses, P_DATA 0x01 then 0xFF.
REQ-034 RST pulsed during DATA bit 4 -> no pulse issued, all outputs 0; a following frame 0x55 -> Data_valid with P_DATA=0x55; with UART_RX_MAJ_VOTE_EN defined, an added 1-cycle inverted glitch at the centre sample -> still 0x55.
